// File: rtl/rx_snapshot_capture.sv
// rx_snapshot_capture: triggered circular snapshot of the 128-bit receive
// sample bus (eight signed 16-bit lanes, lane 0 in bits [15:0]). Once armed it
// records continuously, freezes a window around a software or level trigger,
// and streams the frozen window oldest-first for DMA.
//
// Readout handshake: a word transfers on a rising edge where rd_valid and
// rd_ready are both high. Once rd_valid is high it stays high, and rd_data and
// rd_last hold, until that transfer. rd_last is high only with the final
// (DEPTH-th) word of the window.
module rx_snapshot_capture #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [127:0]          data_in,
  input  logic                  arm,
  input  logic                  trig_mode,
  input  logic                  sw_trigger,
  input  logic [15:0]           trig_threshold,
  input  logic [DEPTH_LOG2:0]   post_len,
  input  logic                  rd_start,
  output logic [127:0]          rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] trig_index,
  output logic [2:0]            dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_C   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] ZERO_C  = '0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_POST    = 3'd2,
    ST_DONE    = 3'd3,
    ST_READOUT = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Input stage S and the trigger pulse aligned with it
  logic [127:0] s_data;
  logic         sw_trig_s;

  // Capture bookkeeping
  logic                  prime;      // first ARMED cycle: S still holds pre-arm data
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   fill;
  logic [DEPTH_LOG2:0]   remaining;
  logic [DEPTH_LOG2:0]   p_eff_q;    // effective post length latched at arm
  logic [DEPTH_LOG2:0]   p_eff_in;

  // Readout pipeline: RAM read register, skid register, output register
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DEPTH_LOG2:0]   rd_cnt;
  logic [127:0]          ram_q;
  logic                  ram_q_v;
  logic                  ram_q_last;
  logic [127:0]          skid_data;
  logic                  skid_last;
  logic                  skid_v;

  logic [127:0] mem [DEPTH];

  logic       lvl_hit;
  logic       trig_hit;
  logic       eligible;
  logic       arm_write;
  logic       wr_en;
  logic       fire;
  logic       pop;
  logic       issue;
  logic [1:0] occ;

  assign dbg_state = state_q;
  assign busy      = (state_q == ST_ARMED) || (state_q == ST_POST) ||
                     (state_q == ST_READOUT);

  // Effective post-trigger length: 0 behaves as 1, anything above DEPTH as DEPTH
  always_comb begin
    p_eff_in = post_len;
    if (post_len == ZERO_C) p_eff_in = ONE_C;
    else if (post_len > DEPTH_C) p_eff_in = DEPTH_C;
  end

  // Signed level compare: any lane of S strictly above the threshold
  always_comb begin
    lvl_hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ($signed(s_data[16*i +: 16]) > $signed(trig_threshold)) lvl_hit = 1'b1;
    end
  end

  // Write enable, trigger qualification and readout issue control
  always_comb begin
    trig_hit  = sw_trig_s | (trig_mode & lvl_hit);
    eligible  = fill >= (DEPTH_C - p_eff_q);
    arm_write = (state_q == ST_ARMED) && !prime;
    wr_en     = (arm_write || (state_q == ST_POST)) && !arm;
    fire      = arm_write && eligible && trig_hit && !arm;
    pop       = rd_valid & rd_ready;
    occ       = {1'b0, rd_valid} + {1'b0, skid_v} + {1'b0, ram_q_v};
    // Keep at most two words beyond the RAM so the skid register never overflows
    issue     = (state_q == ST_READOUT) && !arm && (rd_cnt < DEPTH_C) &&
                (occ <= ({1'b0, pop} + 2'd1));
  end

  // Next-state logic; arm overrides everything, including a same-cycle trigger
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED:   if (fire) state_d = (p_eff_q == ONE_C) ? ST_DONE : ST_POST;
      ST_POST:    if (remaining == ONE_C) state_d = ST_DONE;
      ST_DONE:    if (rd_start) state_d = ST_READOUT;
      ST_READOUT: if (pop && rd_last) state_d = ST_DONE;
      default:    ;
    endcase
    if (arm) state_d = ST_ARMED;
  end

  // Input stage: register the sample bus and the software trigger together
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_data    <= '0;
      sw_trig_s <= 1'b0;
    end else begin
      s_data    <= data_in;
      sw_trig_s <= sw_trigger;
    end
  end

  // State register and capture counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prime      <= 1'b0;
      wr_ptr     <= '0;
      fill       <= '0;
      remaining  <= '0;
      p_eff_q    <= ONE_C;
      done       <= 1'b0;
      trig_index <= '0;
    end else begin
      state_q <= state_d;
      prime   <= arm;
      if (arm) begin
        wr_ptr  <= '0;
        fill    <= '0;
        done    <= 1'b0;
        p_eff_q <= p_eff_in;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (fill != DEPTH_C) fill <= fill + ONE_C;
        end
        if (fire) begin
          trig_index <= wr_ptr;
          remaining  <= p_eff_q - ONE_C;
        end else if (state_q == ST_POST) begin
          remaining <= remaining - ONE_C;
        end
        if (((state_q == ST_ARMED) || (state_q == ST_POST)) && (state_d == ST_DONE))
          done <= 1'b1;
      end
    end
  end

  // Sample buffer: one write port from S, one registered read port
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= s_data;
    if (issue) ram_q <= mem[rd_addr];
  end

  // Readout address generation and output/skid registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr    <= '0;
      rd_cnt     <= '0;
      ram_q_v    <= 1'b0;
      ram_q_last <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_v     <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      rd_valid   <= 1'b0;
    end else if (arm) begin
      rd_cnt   <= '0;
      ram_q_v  <= 1'b0;
      skid_v   <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      // The oldest word sits where the next write would have gone
      if ((state_q == ST_DONE) && rd_start) begin
        rd_addr <= wr_ptr;
        rd_cnt  <= '0;
      end else if (issue) begin
        rd_addr <= rd_addr + 1'b1;
        rd_cnt  <= rd_cnt + ONE_C;
      end
      ram_q_v <= issue;
      if (issue) ram_q_last <= (rd_cnt == (DEPTH_C - ONE_C));

      if (pop || !rd_valid) begin
        if (skid_v) begin
          rd_data   <= skid_data;
          rd_last   <= skid_last;
          rd_valid  <= 1'b1;
          skid_v    <= ram_q_v;
          skid_data <= ram_q;
          skid_last <= ram_q_last;
        end else begin
          rd_valid <= ram_q_v;
          rd_last  <= ram_q_v & ram_q_last;
          if (ram_q_v) rd_data <= ram_q;
        end
      end else if (ram_q_v) begin
        skid_v    <= 1'b1;
        skid_data <= ram_q;
        skid_last <= ram_q_last;
      end
    end
  end

endmodule
